// File: rtl/l2_dir.sv
// Two-client L2 directory with a small backing store.
// Serves one L1.5 request at a time, forwarding STORE_FWD/INV_FWD to the other client when it holds the line.
`ifndef MSG_WIDTH
`define MSG_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 0
`endif
`ifndef MSG_TYPE_LOAD_REQ
`define MSG_TYPE_LOAD_REQ 1
`endif
`ifndef MSG_TYPE_STORE_REQ
`define MSG_TYPE_STORE_REQ 2
`endif
`ifndef MSG_TYPE_DATA_ACK
`define MSG_TYPE_DATA_ACK 3
`endif
`ifndef MSG_TYPE_WB_REQ
`define MSG_TYPE_WB_REQ 4
`endif
`ifndef MSG_TYPE_LOAD_FWD
`define MSG_TYPE_LOAD_FWD 5
`endif
`ifndef MSG_TYPE_STORE_FWD
`define MSG_TYPE_STORE_FWD 6
`endif
`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 7
`endif
`ifndef MSG_TYPE_STORE_FWDACK
`define MSG_TYPE_STORE_FWDACK 8
`endif
`ifndef MSG_TYPE_INV_FWDACK
`define MSG_TYPE_INV_FWDACK 9
`endif

module l2_dir #(
    parameter int MEM_AW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`MSG_WIDTH-1:0]  c0_msg1_type,
    input  logic [`DATA_WIDTH-1:0] c0_msg1_data,
    input  logic [`TAG_WIDTH-1:0]  c0_msg1_tag,
    input  logic [`MSG_WIDTH-1:0]  c0_msg3_type,
    input  logic [`DATA_WIDTH-1:0] c0_msg3_data,
    input  logic [`TAG_WIDTH-1:0]  c0_msg3_tag,
    output logic [`MSG_WIDTH-1:0]  c0_msg2_type,
    output logic [`DATA_WIDTH-1:0] c0_msg2_data,
    output logic [`TAG_WIDTH-1:0]  c0_msg2_tag,
    input  logic [`MSG_WIDTH-1:0]  c1_msg1_type,
    input  logic [`DATA_WIDTH-1:0] c1_msg1_data,
    input  logic [`TAG_WIDTH-1:0]  c1_msg1_tag,
    input  logic [`MSG_WIDTH-1:0]  c1_msg3_type,
    input  logic [`DATA_WIDTH-1:0] c1_msg3_data,
    input  logic [`TAG_WIDTH-1:0]  c1_msg3_tag,
    output logic [`MSG_WIDTH-1:0]  c1_msg2_type,
    output logic [`DATA_WIDTH-1:0] c1_msg2_data,
    output logic [`TAG_WIDTH-1:0]  c1_msg2_tag,
    output logic                   err
);

    localparam int MW     = `MSG_WIDTH;
    localparam int DW     = `DATA_WIDTH;
    localparam int TW     = `TAG_WIDTH;
    localparam int NLINES = 1 << MEM_AW;

    localparam logic [MW-1:0] T_EMPTY     = MW'(`MSG_TYPE_EMPTY);
    localparam logic [MW-1:0] T_LOAD_REQ  = MW'(`MSG_TYPE_LOAD_REQ);
    localparam logic [MW-1:0] T_STORE_REQ = MW'(`MSG_TYPE_STORE_REQ);
    localparam logic [MW-1:0] T_DATA_ACK  = MW'(`MSG_TYPE_DATA_ACK);
    localparam logic [MW-1:0] T_WB_REQ    = MW'(`MSG_TYPE_WB_REQ);
    localparam logic [MW-1:0] T_STORE_FWD = MW'(`MSG_TYPE_STORE_FWD);
    localparam logic [MW-1:0] T_INV_FWD   = MW'(`MSG_TYPE_INV_FWD);
    localparam logic [MW-1:0] T_STORE_ACK = MW'(`MSG_TYPE_STORE_FWDACK);
    localparam logic [MW-1:0] T_INV_ACK   = MW'(`MSG_TYPE_INV_FWDACK);

    typedef enum logic [2:0] {IDLE, FWD, WAIT1, WAIT2, RESP, HOLD} state_e;
    typedef enum logic [1:0] {CST_I, CST_S, CST_M} cst_e;

    logic [MW-1:0] m1Type [2];
    logic [TW-1:0] m1Tag  [2];
    logic [MW-1:0] m3Type [2];
    logic [DW-1:0] m3Data [2];

    state_e        state_q, state_d;
    logic          cur_q, cur_d;
    logic          store_q, store_d;
    logic          fwdInv_q, fwdInv_d;
    logic          last_q, last_d;
    logic [TW-1:0] tag_q, tag_d;
    cst_e          cst_q [2];
    cst_e          cst_d [2];
    logic [TW-1:0] ctag_q [2];
    logic [TW-1:0] ctag_d [2];
    logic [DW-1:0] mem_q [NLINES];
    logic [DW-1:0] mem_d [NLINES];
    logic [MW-1:0] m2Type_q [2];
    logic [MW-1:0] m2Type_d [2];
    logic [DW-1:0] m2Data_q [2];
    logic [DW-1:0] m2Data_d [2];
    logic [TW-1:0] m2Tag_q [2];
    logic [TW-1:0] m2Tag_d [2];
    logic          err_q, err_d;

    logic          elig0, elig1, arbWin, othC, reqStore;
    logic [TW-1:0] reqTag;
    logic [MW-1:0] ackWant;
    logic          unusedInputs;

    assign m1Type[0] = c0_msg1_type;
    assign m1Type[1] = c1_msg1_type;
    assign m1Tag[0]  = c0_msg1_tag;
    assign m1Tag[1]  = c1_msg1_tag;
    assign m3Type[0] = c0_msg3_type;
    assign m3Type[1] = c1_msg3_type;
    assign m3Data[0] = c0_msg3_data;
    assign m3Data[1] = c1_msg3_data;

    // Request data and response tags carry nothing the directory needs.
    assign unusedInputs = ^{c0_msg1_data, c1_msg1_data, c0_msg3_tag, c1_msg3_tag};

    assign elig0    = (c0_msg1_type == T_LOAD_REQ) || (c0_msg1_type == T_STORE_REQ);
    assign elig1    = (c1_msg1_type == T_LOAD_REQ) || (c1_msg1_type == T_STORE_REQ);
    assign arbWin   = (elig0 && elig1) ? ~last_q : elig1;
    assign othC     = (state_q == IDLE) ? ~arbWin : ~cur_q;
    assign reqTag   = m1Tag[arbWin];
    assign reqStore = (m1Type[arbWin] == T_STORE_REQ);
    assign ackWant  = fwdInv_q ? T_INV_ACK : T_STORE_ACK;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        store_d  = store_q;
        fwdInv_d = fwdInv_q;
        last_d   = last_q;
        tag_d    = tag_q;
        cst_d    = cst_q;
        ctag_d   = ctag_q;
        mem_d    = mem_q;
        err_d    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m2Type_d[i] = T_EMPTY;
            m2Data_d[i] = '0;
            m2Tag_d[i]  = '0;
        end

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    cur_d   = arbWin;
                    tag_d   = reqTag;
                    store_d = reqStore;
                    last_d  = arbWin;
                    // A dirty line being evicted by the new request is written back first.
                    if (m3Type[arbWin] == T_WB_REQ && cst_q[arbWin] == CST_M &&
                        ctag_q[arbWin] != reqTag) begin
                        mem_d[ctag_q[arbWin][MEM_AW-1:0]] = m3Data[arbWin];
                        cst_d[arbWin] = CST_I;
                    end
                    if (ctag_q[othC] == reqTag && cst_q[othC] == CST_M) begin
                        fwdInv_d = 1'b0;
                        state_d  = FWD;
                    end else if (ctag_q[othC] == reqTag && cst_q[othC] == CST_S && reqStore) begin
                        fwdInv_d = 1'b1;
                        state_d  = FWD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            FWD: begin
                m2Type_d[othC] = fwdInv_q ? T_INV_FWD : T_STORE_FWD;
                m2Tag_d[othC]  = tag_q;
                state_d        = WAIT1;
            end
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                if (m3Type[othC] == ackWant) begin
                    if (!fwdInv_q) begin
                        mem_d[tag_q[MEM_AW-1:0]] = m3Data[othC];
                    end
                    cst_d[othC] = CST_I;
                end else begin
                    err_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                m2Type_d[cur_q] = T_DATA_ACK;
                m2Data_d[cur_q] = mem_q[tag_q[MEM_AW-1:0]];
                m2Tag_d[cur_q]  = tag_q;
                ctag_d[cur_q]   = tag_q;
                cst_d[cur_q]    = store_q ? CST_M : CST_S;
                state_d         = HOLD;
            end
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts any transaction in flight and clears directory and store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= 1'b0;
            store_q  <= 1'b0;
            fwdInv_q <= 1'b0;
            last_q   <= 1'b1;
            tag_q    <= '0;
            cst_q    <= '{default: CST_I};
            ctag_q   <= '{default: '0};
            mem_q    <= '{default: '0};
            m2Type_q <= '{default: '0};
            m2Data_q <= '{default: '0};
            m2Tag_q  <= '{default: '0};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            store_q  <= store_d;
            fwdInv_q <= fwdInv_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            cst_q    <= cst_d;
            ctag_q   <= ctag_d;
            mem_q    <= mem_d;
            m2Type_q <= m2Type_d;
            m2Data_q <= m2Data_d;
            m2Tag_q  <= m2Tag_d;
            err_q    <= err_d;
        end
    end

    assign c0_msg2_type = m2Type_q[0];
    assign c0_msg2_data = m2Data_q[0];
    assign c0_msg2_tag  = m2Tag_q[0];
    assign c1_msg2_type = m2Type_q[1];
    assign c1_msg2_data = m2Data_q[1];
    assign c1_msg2_tag  = m2Tag_q[1];
    assign err          = err_q;

endmodule

// File: tb/tb_l2_dir.sv
// Directed scoreboard bench for l2_dir: expected msg2/err events are queued with their cycle,
// and a negedge monitor pops and compares every non-empty output it sees.
module tb_l2_dir;

    localparam logic [3:0] EMPTY     = 4'd0;
    localparam logic [3:0] LOAD_REQ  = 4'd1;
    localparam logic [3:0] STORE_REQ = 4'd2;
    localparam logic [3:0] DATA_ACK  = 4'd3;
    localparam logic [3:0] WB_REQ    = 4'd4;
    localparam logic [3:0] STORE_FWD = 4'd6;
    localparam logic [3:0] INV_FWD   = 4'd7;
    localparam logic [3:0] STORE_ACK = 4'd8;
    localparam logic [3:0] INV_ACK   = 4'd9;

    typedef struct {
        int         cl;
        logic [3:0] ty;
        logic [7:0] data;
        logic [7:0] tag;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] c0_msg1_type = '0, c1_msg1_type = '0, c0_msg3_type = '0, c1_msg3_type = '0;
    logic [7:0] c0_msg1_data = '0, c1_msg1_data = '0, c0_msg3_data = '0, c1_msg3_data = '0;
    logic [7:0] c0_msg1_tag = '0, c1_msg1_tag = '0, c0_msg3_tag = '0, c1_msg3_tag = '0;
    logic [3:0] c0_msg2_type, c1_msg2_type;
    logic [7:0] c0_msg2_data, c1_msg2_data, c0_msg2_tag, c1_msg2_tag;
    logic       err;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   n;
    exp_t sbq[$];

    l2_dir #(.MEM_AW(4)) dut (
        .clk(clk), .rst(rst),
        .c0_msg1_type(c0_msg1_type), .c0_msg1_data(c0_msg1_data), .c0_msg1_tag(c0_msg1_tag),
        .c0_msg3_type(c0_msg3_type), .c0_msg3_data(c0_msg3_data), .c0_msg3_tag(c0_msg3_tag),
        .c0_msg2_type(c0_msg2_type), .c0_msg2_data(c0_msg2_data), .c0_msg2_tag(c0_msg2_tag),
        .c1_msg1_type(c1_msg1_type), .c1_msg1_data(c1_msg1_data), .c1_msg1_tag(c1_msg1_tag),
        .c1_msg3_type(c1_msg3_type), .c1_msg3_data(c1_msg3_data), .c1_msg3_tag(c1_msg3_tag),
        .c1_msg2_type(c1_msg2_type), .c1_msg2_data(c1_msg2_data), .c1_msg2_tag(c1_msg2_tag),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectEv(input int cl, input logic [3:0] ty, input logic [7:0] d,
                            input logic [7:0] tg, input int at);
        exp_t e;
        e.cl = cl; e.ty = ty; e.data = d; e.tag = tg; e.at = at;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input int cl, input logic [3:0] ty, input logic [7:0] tg);
        if (cl == 0) begin
            c0_msg1_type = ty; c0_msg1_tag = tg;
        end else begin
            c1_msg1_type = ty; c1_msg1_tag = tg;
        end
    endtask

    task automatic setMsg3(input int cl, input logic [3:0] ty, input logic [7:0] d);
        if (cl == 0) begin
            c0_msg3_type = ty; c0_msg3_data = d;
        end else begin
            c1_msg3_type = ty; c1_msg3_data = d;
        end
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req)
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        else
            passes++;
    endtask

    task automatic observe(input int cl, input logic [3:0] ty, input logic [7:0] d, input logic [7:0] tg);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            $display("[TB] FAIL unexpected event ch%0d: got type %0d data %h tag %h at cycle %0d, required none",
                     cl, ty, d, tg, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.cl != cl || e.ty != ty || e.data != d || e.tag != tg || e.at != cyc)
                $display("[TB] FAIL event: got ch%0d type %0d data %h tag %h cycle %0d, required ch%0d type %0d data %h tag %h cycle %0d",
                         cl, ty, d, tg, cyc, e.cl, e.ty, e.data, e.tag, e.at);
            else
                passes++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (c0_msg2_type != EMPTY) observe(0, c0_msg2_type, c0_msg2_data, c0_msg2_tag);
            if (c1_msg2_type != EMPTY) observe(1, c1_msg2_type, c1_msg2_data, c1_msg2_tag);
            if (err) observe(2, 4'd1, 8'h00, 8'h00);
        end
    end

    initial begin
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset c0_msg2", {12'h0, c0_msg2_type, c0_msg2_data, c0_msg2_tag}, 32'h0);
            checkOutput("reset c1_msg2+err", {11'h0, err, c1_msg2_type, c1_msg2_data, c1_msg2_tag}, 32'h0);
        end
        rst = 1'b0;

        // c0 LOAD 3 from cold: no forward, data 0
        n = cyc;
        applyStimulus(0, LOAD_REQ, 8'h03);
        expectEv(0, DATA_ACK, 8'h00, 8'h03, n + 2);
        waitCyc(n + 2); applyStimulus(0, EMPTY, 8'h00);
        waitCyc(n + 3);

        // c1 STORE 3 while c0 shares it: INV_FWD to c0
        n = cyc;
        applyStimulus(1, STORE_REQ, 8'h03);
        expectEv(0, INV_FWD, 8'h00, 8'h03, n + 2);
        expectEv(1, DATA_ACK, 8'h00, 8'h03, n + 5);
        waitCyc(n + 3); setMsg3(0, INV_ACK, 8'h00);
        waitCyc(n + 5); applyStimulus(1, EMPTY, 8'h00); setMsg3(0, EMPTY, 8'h00);
        waitCyc(n + 6);

        // c0 LOAD 3 while c1 owns it: STORE_FWD, write-back data A5 returned
        n = cyc;
        applyStimulus(0, LOAD_REQ, 8'h03);
        expectEv(1, STORE_FWD, 8'h00, 8'h03, n + 2);
        expectEv(0, DATA_ACK, 8'hA5, 8'h03, n + 5);
        waitCyc(n + 3); setMsg3(1, STORE_ACK, 8'hA5);
        waitCyc(n + 5); applyStimulus(0, EMPTY, 8'h00); setMsg3(1, EMPTY, 8'h00);
        waitCyc(n + 6);

        // c1 regains M on tag 3, invalidating c0
        n = cyc;
        applyStimulus(1, STORE_REQ, 8'h03);
        expectEv(0, INV_FWD, 8'h00, 8'h03, n + 2);
        expectEv(1, DATA_ACK, 8'hA5, 8'h03, n + 5);
        waitCyc(n + 3); setMsg3(0, INV_ACK, 8'h00);
        waitCyc(n + 5); applyStimulus(1, EMPTY, 8'h00); setMsg3(0, EMPTY, 8'h00);
        waitCyc(n + 6);

        // c1 STORE 5 evicting dirty tag 3 with WB data 5A
        n = cyc;
        applyStimulus(1, STORE_REQ, 8'h05); setMsg3(1, WB_REQ, 8'h5A);
        expectEv(1, DATA_ACK, 8'h00, 8'h05, n + 2);
        waitCyc(n + 2); applyStimulus(1, EMPTY, 8'h00); setMsg3(1, EMPTY, 8'h00);
        waitCyc(n + 3);

        // c0 LOAD 3 sees the written-back 5A, then aliasing tag 13 hits the same line
        n = cyc;
        applyStimulus(0, LOAD_REQ, 8'h03);
        expectEv(0, DATA_ACK, 8'h5A, 8'h03, n + 2);
        waitCyc(n + 2); applyStimulus(0, EMPTY, 8'h00);
        waitCyc(n + 3);
        n = cyc;
        applyStimulus(0, LOAD_REQ, 8'h13);
        expectEv(0, DATA_ACK, 8'h5A, 8'h13, n + 2);
        waitCyc(n + 2); applyStimulus(0, EMPTY, 8'h00);
        waitCyc(n + 3);

        // c0 STORE 5 forwards to c1, then reset aborts mid-transaction
        n = cyc;
        applyStimulus(0, STORE_REQ, 8'h05);
        expectEv(1, STORE_FWD, 8'h00, 8'h05, n + 2);
        waitCyc(n + 2);
        #2 rst = 1'b1;
        waitCyc(n + 3);
        applyStimulus(1, LOAD_REQ, 8'h03);
        checkOutput("midreset c0_msg2", {12'h0, c0_msg2_type, c0_msg2_data, c0_msg2_tag}, 32'h0);
        checkOutput("midreset c1_msg2+err", {11'h0, err, c1_msg2_type, c1_msg2_data, c1_msg2_tag}, 32'h0);
        waitCyc(n + 4);
        rst = 1'b0;
        // both held after reset: c0 first (no forward, store cleared), c1 after HOLD reads cleared line 3
        expectEv(0, DATA_ACK, 8'h00, 8'h05, n + 6);
        expectEv(1, DATA_ACK, 8'h00, 8'h03, n + 9);
        waitCyc(n + 6); applyStimulus(0, EMPTY, 8'h00);
        waitCyc(n + 9); applyStimulus(1, EMPTY, 8'h00);
        waitCyc(n + 10);

        // c1 STORE 5 forwards to owner c0, which answers with the wrong ack type
        n = cyc;
        applyStimulus(1, STORE_REQ, 8'h05);
        expectEv(0, STORE_FWD, 8'h00, 8'h05, n + 2);
        expectEv(2, 4'd1, 8'h00, 8'h00, n + 4);
        expectEv(1, DATA_ACK, 8'h00, 8'h05, n + 5);
        waitCyc(n + 3); setMsg3(0, INV_ACK, 8'h77);
        waitCyc(n + 5); applyStimulus(1, EMPTY, 8'h00); setMsg3(0, EMPTY, 8'h00);
        waitCyc(n + 6);

        // c0 LOAD 5: c1 now owns it, returns 3C
        n = cyc;
        applyStimulus(0, LOAD_REQ, 8'h05);
        expectEv(1, STORE_FWD, 8'h00, 8'h05, n + 2);
        expectEv(0, DATA_ACK, 8'h3C, 8'h05, n + 5);
        waitCyc(n + 3); setMsg3(1, STORE_ACK, 8'h3C);
        waitCyc(n + 5); applyStimulus(0, EMPTY, 8'h00); setMsg3(1, EMPTY, 8'h00);
        waitCyc(n + 6);

        // simultaneous requests after c0 was served: round-robin picks c1 first
        n = cyc;
        applyStimulus(0, LOAD_REQ, 8'h07);
        applyStimulus(1, LOAD_REQ, 8'h09);
        expectEv(1, DATA_ACK, 8'h00, 8'h09, n + 2);
        expectEv(0, DATA_ACK, 8'h00, 8'h07, n + 5);
        waitCyc(n + 2); applyStimulus(1, EMPTY, 8'h00);
        waitCyc(n + 5); applyStimulus(0, EMPTY, 8'h00);
        waitCyc(n + 8);

        checks++;
        if (sbq.size() != 0)
            $display("[TB] FAIL scoreboard drain: got %0d pending events, required 0", sbq.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/l2_dir.md
L2_DIR -- requirements
Module: l2_dir

Interface
REQ-001 SHALL have parameter MEM_AW, default 4, meaning backing-store index width; the store holds 2^MEM_AW lines indexed by tag[MEM_AW-1:0], and tags aliasing to the same index share a line.
REQ-002 SHALL take message field widths from ccp_define.h: `MSG_WIDTH, `DATA_WIDTH, `TAG_WIDTH.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- cN_msg1_type/_data/_tag  in  MSG/DATA/TAG  request channel from L1.5 client N (N=0,1); held by the client until DATA_ACK.
- cN_msg3_type/_data/_tag  in  MSG/DATA/TAG  response/write-back channel from client N; a registered level, not a pulse.
- cN_msg2_type/_data/_tag  out  MSG/DATA/TAG  forward/data channel to client N; registered.
- err  out  1  one-cycle pulse on a protocol error.

Function
REQ-004 SHALL keep per-client directory state: cst[N] in {I,S,M} and ctag[N].
REQ-005 SHALL run an FSM with states IDLE, FWD, WAIT1, WAIT2, RESP, HOLD.
REQ-006 Every non-EMPTY msg2 SHALL be a one-cycle pulse; msg2_type SHALL return to EMPTY on the next cycle.
REQ-007 In IDLE, a client is eligible when its msg1_type is LOAD_REQ or STORE_REQ and it is not the HOLD client.
- Arbitration is round-robin; the last-served pointer resets to 1, so client 0 wins first.
- The chosen client c, request type, and tag T are latched at the accepting edge.
REQ-008 At the accepting edge, if c_msg3_type==WB_REQ, cst[c]==M and ctag[c]!=T, SHALL write c_msg3_data to mem[ctag[c]] and set cst[c]=I.
REQ-009 Forward decision for other client o, applied when ctag[o]==T:
- cst[o]==M (LOAD or STORE) -> STORE_FWD to o.
- cst[o]==S and STORE -> INV_FWD to o.
- Otherwise -> no forward.
- LOAD_FWD is never issued.
REQ-010 With a forward: IDLE->FWD. FWD drives o_msg2 = {type, tag T}, then WAIT1->WAIT2.
- In WAIT2, o_msg3_type SHALL be sampled: STORE_FWDACK for STORE_FWD, INV_FWDACK for INV_FWD.
- On STORE_FWDACK, write o_msg3_data to mem[T].
- Set cst[o]=I, then go to RESP.
REQ-011 In WAIT2, a mismatched ack type SHALL pulse err, leave cst[o] and mem unchanged, and still go to RESP.
REQ-012 Without a forward: IDLE->RESP.
REQ-013 In RESP, SHALL drive c_msg2 = {DATA_ACK, mem[T] (including any same-edge write), T}.
- Set ctag[c]=T; cst[c]=S for LOAD, M for STORE.
- Then go to HOLD.
REQ-014 HOLD SHALL last one cycle, during which client c is ineligible (its msg1 is still stale); then go to IDLE.
REQ-015 Latency, with request accepted at edge t:
- No forward: DATA_ACK is visible after edge t+1.
- Forward: the forward is visible after t+1, the ack is sampled at t+3, and DATA_ACK is visible after t+4.
REQ-016 Simultaneous requests from both clients SHALL be served one at a time; the loser's held request is served after the winner's HOLD.
REQ-017 Only one transaction SHALL be in flight; msg1 changes outside IDLE are ignored.

Reset
REQ-018 While rst is high, asynchronously:
- All msg2 outputs = 0 (EMPTY), err = 0.
- cst[0..1] = I, ctag = 0, FSM = IDLE, pointer = 1.
- mem contents are preset to 0.
REQ-019 Asserting rst mid-transaction SHALL abort it immediately with no mem or directory update; after deassertion, held requests are re-arbitrated from IDLE.

Verification
REQ-020 After reset, c0 LOAD tag 3 -> c0_msg2 DATA_ACK, data 0, tag 3, one cycle after acceptance; cst[0]=S.
REQ-021 c0 holds S tag 3, c1 STORE tag 3 -> INV_FWD to c0; c0 returns INV_FWDACK two edges later; DATA_ACK to c1; cst[0]=I, cst[1]=M.
REQ-022 c1 holds M tag 3, c0 LOAD tag 3, c1 answers STORE_FWDACK data 0xA5 -> mem[3]=0xA5; c0 receives DATA_ACK data 0xA5.
REQ-023 c1 holds M tag 3, c1 STORE tag 5 with WB_REQ data 0x5A -> mem[3]=0x5A; DATA_ACK tag 5 to c1 with no forward.
REQ-024 Both clients request on the same edge after reset -> c0 is served first and c1 is served after c0's HOLD; a wrong ack type in WAIT2 -> err pulses for one cycle.
